// File: rtl/c432_irq_event_queue.sv
// Capture stage for the c432 interrupt priority outputs: it debounces {grp,code} and queues each stable active vector.
// Define C432_IRQ_SYNC_EN to pass the inputs through a 2-flop synchronizer when the source is asynchronous.
module c432_irq_event_queue #(
  parameter int DEPTH  = 4,
  parameter int STABLE = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [2:0]                 grp_in,
  input  logic [3:0]                 code_in,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output logic [2:0]                 ev_grp,
  output logic [3:0]                 ev_code,
  output logic [$clog2(DEPTH):0]     ev_count,
  output logic                       ovf,
  input  logic                       ovf_clr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [3:0]    STABLE_M1 = 4'(STABLE - 1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, QUAL, HOLD} state_t;

  logic [6:0] s;
  logic       s_act;

`ifdef C432_IRQ_SYNC_EN
  logic [6:0] sync1, sync2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      s     <= '0;
    end else begin
      sync1 <= {grp_in, code_in};
      sync2 <= sync1;
      s     <= sync2;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s <= '0;
    else        s <= {grp_in, code_in};
  end
`endif

  assign s_act = |s[6:4];

  state_t     state, state_nxt;
  logic [6:0] cand, cand_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cand  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cand  <= cand_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // HOLD with a changed vector is handled exactly like IDLE
  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    push      = 1'b0;
    case (state)
      QUAL: begin
        if (s != cand) begin
          if (s_act) begin
            cand_nxt = s;
            cnt_nxt  = 4'd1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (cnt == STABLE_M1) begin
          push      = 1'b1;
          state_nxt = HOLD;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: begin
        if (state == HOLD && s == cand) begin
          state_nxt = HOLD;
        end else if (s_act) begin
          cand_nxt = s;
          cnt_nxt  = 4'd1;
          if (STABLE == 1) begin
            push      = 1'b1;
            state_nxt = HOLD;
          end else begin
            state_nxt = QUAL;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  logic [6:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          pop, full, push_ok, drop;

  assign pop     = (count != '0) && ev_ready;
  assign full    = (count == CNT_FULL);
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // a drop in the same cycle as a clear leaves ovf set
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  assign ev_valid = (count != '0);
  assign ev_count = count;
  assign ev_grp   = ev_valid ? mem[rd_ptr][6:4] : 3'b000;
  assign ev_code  = ev_valid ? mem[rd_ptr][3:0] : 4'b0000;

endmodule
